skin_pipe_ctrl: RTL and testbench
=================================

SKIN_PIPE_CTRL -- requirements
Module: skin_pipe_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 6: clock edges from the pixel on dp_* to the result on dp_*_res.
REQ-002 SHALL have parameter DEPTH, default 8: output FIFO entries, which is also the credit limit.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  source pixel valid.
- s_ready  out  1  source may transfer.
- s_y, s_cb, s_cr  in  8 each  source pixel.
- s_last  in  1  last pixel of frame.
- dp_y, dp_cb, dp_cr  out  8 each  to the free-running transcb/transcr datapath.
- dp_cb_res, dp_cr_res  in  8 each  datapath results.
- m_valid  out  1  result valid.
- m_ready  in  1  sink accepts.
- m_cb, m_cr  out  8 each  result pixel.
- m_last  out  1  last result of frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse.
- pix_count  out  16  pixels accepted in the current or most recent frame.

Function
REQ-004 SHALL define accept = s_valid & s_ready; each accept issues one pixel to the datapath.
REQ-005 SHALL drive dp_y/dp_cb/dp_cr combinationally equal to s_y/s_cb/s_cr on accept cycles and 8'h00 otherwise.
REQ-006 SHALL carry a valid+last tag through a LATENCY-stage shift register; the tag entered at the end of accept cycle t SHALL mark dp_*_res valid during cycle t+LATENCY.
REQ-007 SHALL push {dp_cb_res, dp_cr_res, tag.last} into the output FIFO at the end of every cycle whose final tag stage is valid.
REQ-008 SHALL define inflight as the count of valid tags and occupancy as the FIFO count, both registered.
REQ-009 SHALL assert s_ready only when all of the following hold: not rst, state != DRAIN, and inflight + occupancy < DEPTH. This credit rule makes FIFO overflow impossible.
REQ-010 SHALL implement the output FIFO as first-word fall-through: m_valid = (occupancy != 0), and m_cb/m_cr/m_last come from the head entry.
REQ-011 SHALL pop the FIFO on m_valid & m_ready; simultaneous push and pop SHALL leave occupancy unchanged; pop when empty SHALL be impossible (m_valid=0).
REQ-012 SHALL hold m_cb, m_cr and m_last stable while m_valid=1 and m_ready=0.
REQ-013 SHALL implement FSM states IDLE, RUN and DRAIN; busy = (state != IDLE).
REQ-014 SHALL transition IDLE->RUN on an accept with s_last=0, and IDLE->DRAIN on an accept with s_last=1 (one-pixel frame).
REQ-015 SHALL transition RUN->DRAIN on an accept with s_last=1.
REQ-016 SHALL transition DRAIN->IDLE on the cycle m_valid & m_ready & m_last; frame_done SHALL pulse high in exactly that cycle.
REQ-017 SHALL count pix_count as follows: set to 1 on an accept in IDLE; increment by 1 on each accept in RUN; hold in DRAIN and IDLE.
REQ-018 SHALL saturate pix_count at 16'hFFFF.
REQ-019 SHALL have a fixed accept-to-m_valid latency of LATENCY+1 cycles when the FIFO is empty and m_ready=1.

Reset
REQ-020 SHALL, while rst=1, clear state to IDLE, all tags, inflight, occupancy and FIFO pointers, and pix_count.
REQ-021 SHALL drive s_ready=0, m_valid=0, m_cb=m_cr=0, m_last=0, busy=0, frame_done=0 and dp_*=0 during reset and on the cycle after reset.
REQ-022 SHALL, on reset mid-frame, discard all in-flight tags; datapath results arriving after reset SHALL never be pushed.

Verification
REQ-023 SHALL cover single pixel: accept Y=100, Cb=120, Cr=150, s_last=1 at cycle 0 with m_ready=1 -> m_valid=1 at cycle 7 with m_cb/m_cr = datapath outputs and m_last=1; frame_done pulses in cycle 7; busy=0 in cycle 8; pix_count=1.
REQ-024 SHALL cover backpressure: m_ready=0 with s_valid held high -> exactly 8 accepts, then s_ready=0; occupancy reaches 8 with no lost or duplicated result. Raising m_ready -> results emerge in order.
REQ-025 SHALL cover streaming: a 64-pixel frame with m_ready=1 -> 64 in-order results; m_last only on result 64; pix_count=64; frame_done pulses once.
REQ-026 SHALL cover DRAIN blocking: after s_last is accepted, s_valid stays high -> s_ready=0 until frame_done; next frame's first accept sets pix_count=1.
REQ-027 SHALL cover reset mid-frame: rst=1 for 1 cycle with 4 pixels in flight -> no m_valid for the following 10 cycles; state IDLE.
REQ-028 SHALL cover random m_ready at 50% toggling -> output order equals input order, and occupancy never exceeds 8.

Source files
------------

// File: rtl/skin_pipe_ctrl.sv
// Skin-tone pipeline controller: credit-based flow control around a fixed-latency
// Cb/Cr transform datapath, with a first-word fall-through result FIFO and frame FSM.
module skin_pipe_ctrl #(
  parameter int unsigned LATENCY = 6,
  parameter int unsigned DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_y,
  input  logic [7:0]  s_cb,
  input  logic [7:0]  s_cr,
  input  logic        s_last,
  output logic [7:0]  dp_y,
  output logic [7:0]  dp_cb,
  output logic [7:0]  dp_cr,
  input  logic [7:0]  dp_cb_res,
  input  logic [7:0]  dp_cr_res,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_cb,
  output logic [7:0]  m_cr,
  output logic        m_last,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pix_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state, state_nxt;
  logic               rst_q;
  logic [LATENCY-1:0] tag_vld, tag_lst;
  logic [CW-1:0]      inflight, occupancy;
  logic [CW:0]        credit_used;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [16:0]        mem [DEPTH];
  logic [16:0]        head;
  logic               accept, push, pop;

  // Credits cover both in-flight tags and stored results, so the FIFO can never overflow.
  assign credit_used = {1'b0, inflight} + {1'b0, occupancy};
  assign s_ready     = !rst && !rst_q && (state != DRAIN) && (credit_used < DEPTH_W);
  assign accept      = s_valid && s_ready;
  assign push        = tag_vld[LATENCY-1];

  assign dp_y  = accept ? s_y  : 8'h00;
  assign dp_cb = accept ? s_cb : 8'h00;
  assign dp_cr = accept ? s_cr : 8'h00;

  assign head       = mem[rd_ptr];
  assign m_valid    = !rst && (occupancy != '0);
  assign pop        = m_valid && m_ready;
  assign m_cb       = m_valid ? head[16:9] : 8'h00;
  assign m_cr       = m_valid ? head[8:1]  : 8'h00;
  assign m_last     = m_valid ? head[0]    : 1'b0;
  assign busy       = !rst && (state != IDLE);
  assign frame_done = (state == DRAIN) && pop && m_last;

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Valid/last tag travels alongside the free-running datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_lst <= '0;
    end else begin
      tag_vld[0] <= accept;
      tag_lst[0] <= accept && s_last;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_lst[i] <= tag_lst[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= '0;
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      inflight  <= inflight + CW'(accept) - CW'(push);
      occupancy <= occupancy + CW'(push) - CW'(pop);
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {dp_cb_res, dp_cr_res, tag_lst[LATENCY-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count <= 16'h0000;
    end else if (accept) begin
      if (state == IDLE) pix_count <= 16'd1;
      else if ((state == RUN) && (pix_count != 16'hFFFF)) pix_count <= pix_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = s_last ? DRAIN : RUN;
      RUN:     if (accept && s_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_skin_pipe_ctrl.sv
// Bench for skin_pipe_ctrl: transaction-level model (queue of expected results with
// accept timestamps, frame flags) checked every cycle, plus directed scenarios.
module tb_skin_pipe_ctrl;

  localparam int LAT = 6;
  localparam int DEP = 8;

  logic        clk, rst;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_y, s_cb, s_cr;
  logic [7:0]  dp_y, dp_cb, dp_cr, dp_cb_res, dp_cr_res;
  logic        m_valid, m_ready, m_last, busy, frame_done;
  logic [7:0]  m_cb, m_cr;
  logic [15:0] pix_count;

  skin_pipe_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_y(s_y), .s_cb(s_cb), .s_cr(s_cr), .s_last(s_last),
    .dp_y(dp_y), .dp_cb(dp_cb), .dp_cr(dp_cr), .dp_cb_res(dp_cb_res), .dp_cr_res(dp_cr_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_cb(m_cb), .m_cr(m_cr), .m_last(m_last),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] f_cb(input logic [7:0] y, input logic [7:0] cb);
    return cb ^ {1'b0, y[7:1]};
  endfunction

  function automatic logic [7:0] f_cr(input logic [7:0] y, input logic [7:0] cr);
    return cr + {2'b00, y[7:2]};
  endfunction

  // Free-running transcb/transcr datapath stand-in with LAT cycles of latency.
  logic [15:0] dpp [LAT];
  always @(posedge clk) begin
    dpp[0] <= {f_cb(dp_y, dp_cb), f_cr(dp_y, dp_cr)};
    for (int i = 1; i < LAT; i++) dpp[i] <= dpp[i-1];
  end
  assign dp_cb_res = dpp[LAT-1][15:8];
  assign dp_cr_res = dpp[LAT-1][7:0];

  typedef struct {
    logic [7:0] cb;
    logic [7:0] cr;
    logic       last;
    int         acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc;
  logic        rst_prev, m_busy, m_drain;
  logic [15:0] m_pix;
  int          checks, errors;
  logic        obs_acc, obs_mv, obs_fd, obs_busy, obs_ready;
  int          n_acc, n_pop, n_lastpop, n_fd, n_mv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t fr;
    logic e_ready, e_valid, e_acc, e_pop;
    fr = '{cb: 8'h00, cr: 8'h00, last: 1'b0, acc_cyc: 0};
    @(negedge clk);
    e_ready = !rst && !rst_prev && !m_drain && (exp_q.size() < DEP);
    e_valid = !rst && (exp_q.size() > 0);
    if (e_valid) begin
      fr = exp_q[0];
      e_valid = (fr.acc_cyc + LAT + 1 <= cyc);
      if (!e_valid) fr = '{cb: 8'h00, cr: 8'h00, last: 1'b0, acc_cyc: 0};
    end
    e_acc = s_valid && e_ready;
    e_pop = e_valid && m_ready;
    chk("s_ready", s_ready, e_ready);
    chk("m_valid", m_valid, e_valid);
    chk("m_cb", m_cb, fr.cb);
    chk("m_cr", m_cr, fr.cr);
    chk("m_last", m_last, fr.last);
    chk("busy", busy, !rst && m_busy);
    chk("frame_done", frame_done, e_pop && fr.last);
    chk("pix_count", pix_count, m_pix);
    chk("dp_y", dp_y, e_acc ? s_y : 8'h00);
    chk("dp_cb", dp_cb, e_acc ? s_cb : 8'h00);
    chk("dp_cr", dp_cr, e_acc ? s_cr : 8'h00);
    obs_acc   = s_valid && s_ready;
    obs_mv    = m_valid;
    obs_fd    = frame_done;
    obs_busy  = busy;
    obs_ready = s_ready;
    if (obs_acc) n_acc++;
    if (m_valid && m_ready) n_pop++;
    if (m_valid && m_ready && m_last) n_lastpop++;
    if (frame_done) n_fd++;
    if (m_valid) n_mv++;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_pix   = 16'h0000;
    end else begin
      if (e_pop) begin
        void'(exp_q.pop_front());
        if (fr.last) begin
          m_busy  = 1'b0;
          m_drain = 1'b0;
        end
      end
      if (e_acc) begin
        exp_q.push_back('{cb: f_cb(s_y, s_cb), cr: f_cr(s_y, s_cr), last: s_last, acc_cyc: cyc});
        if (!m_busy) begin
          m_pix  = 16'd1;
          m_busy = 1'b1;
        end else if (m_pix != 16'hFFFF) begin
          m_pix = m_pix + 16'd1;
        end
        if (s_last) m_drain = 1'b1;
      end
    end
    rst_prev = rst;
    cyc++;
    #1;
  endtask

  task automatic rand_pix();
    s_y  = 8'($urandom);
    s_cb = 8'($urandom);
    s_cr = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int max, input bit rnd_ready);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      step();
      seen = obs_fd;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    logic [8:0] mv_v, fd_v, bz_v;
    int sent, len, nfr;
    checks = 0; errors = 0;
    n_acc = 0; n_pop = 0; n_lastpop = 0; n_fd = 0; n_mv = 0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    s_y = 8'h00; s_cb = 8'h00; s_cr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0; rst_prev = 1'b1; m_busy = 1'b0; m_drain = 1'b0; m_pix = 16'h0000;

    // Reset and the cycle after: source offered but must not be accepted.
    s_valid = 1'b1; rand_pix();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_no_accept", obs_acc, 1'b0);
    s_valid = 1'b0;
    step();

    // Single-pixel frame.
    m_ready = 1'b1; s_valid = 1'b1; s_last = 1'b1;
    s_y = 8'd100; s_cb = 8'd120; s_cr = 8'd150;
    step();
    chk("sp_accept", obs_acc, 1'b1);
    mv_v[0] = obs_mv; fd_v[0] = obs_fd; bz_v[0] = obs_busy;
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      mv_v[k] = obs_mv; fd_v[k] = obs_fd; bz_v[k] = obs_busy;
    end
    chk("sp_mvalid_timing", mv_v, 9'b0_1000_0000);
    chk("sp_done_timing", fd_v, 9'b0_1000_0000);
    chk("sp_busy_timing", bz_v, 9'b0_1111_1110);
    chk("sp_pix", pix_count, 16'd1);

    // Backpressure: credits stop the source at DEPTH.
    n_acc = 0; m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_pix();
      step();
    end
    chk("bp_accepts", n_acc, DEP);
    chk("bp_ready_low", obs_ready, 1'b0);
    n_pop = 0; m_ready = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("bp_pops", n_pop, DEP);
    s_valid = 1'b1; s_last = 1'b1; rand_pix();
    for (int i = 0; i < 20 && !obs_acc; i++) step();
    chk("bp_last_acc", obs_acc, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_done("bp_done_timeout", 50, 1'b0);
    chk("bp_pix", pix_count, 16'd9);

    // 64-pixel stream, then source held valid through DRAIN.
    n_acc = 0; n_pop = 0; n_lastpop = 0; n_fd = 0;
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 1000 && n_acc < 64; i++) begin
      rand_pix();
      s_last = (n_acc == 63);
      step();
    end
    chk("st_accepts", n_acc, 64);
    s_last = 1'b0;
    wait_done("st_done_timeout", 50, 1'b0);
    chk("drain_blocked", n_acc, 64);
    chk("st_pops", n_pop, 64);
    chk("st_last_once", n_lastpop, 1);
    chk("st_done_once", n_fd, 1);
    chk("st_pix", pix_count, 16'd64);
    step();
    chk("nf_accept", obs_acc, 1'b1);
    chk("nf_pix", pix_count, 16'd1);

    // Reset with four pixels in flight.
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      rand_pix();
      step();
    end
    chk("rst_setup", n_acc, 3);
    s_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; n_mv = 0;
    for (int i = 0; i < 10; i++) step();
    chk("rst_no_mvalid", n_mv, 0);
    chk("rst_idle", busy, 1'b0);
    chk("rst_pix", pix_count, 16'd0);

    // Random frames with random source valid and 50% sink ready.
    n_fd = 0; n_lastpop = 0; nfr = 12;
    for (int f = 0; f < nfr; f++) begin
      len = int'($urandom_range(1, 20));
      sent = 0;
      for (int i = 0; i < 2000 && sent < len; i++) begin
        s_valid = ($urandom_range(0, 9) < 7);
        m_ready = 1'($urandom_range(0, 1));
        rand_pix();
        s_last = (sent == len - 1);
        step();
        if (obs_acc) sent++;
      end
      chk("rf_sent", sent, len);
      s_valid = 1'b0; s_last = 1'b0;
      wait_done("rf_done_timeout", 400, 1'b1);
      chk("rf_pix", pix_count, len);
    end
    chk("rf_frames_done", n_fd, nfr);
    chk("rf_last_count", n_lastpop, nfr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
